// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
package hazard_pkg;

    typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} hz_state_t;

    localparam int HZ_REG_AW = 5;

endpackage

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: load-use bubbles, branch flush sequencing, memory freeze.
// Optional macro HAZARD_PERF_CNT_EN adds load-use, redirect and frozen-cycle counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW       = HZ_REG_AW,
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_WAIT     = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_memRead,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              branch_taken,
    input  logic              dmem_busy,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              pipe_en,
    output logic              ctrl_sel,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              flush_exmem,
    output logic              stall_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       perf_lu_stalls,
    output logic [31:0]       perf_flushes,
    output logic [31:0]       perf_mem_waits
`endif
);

    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);

    hz_state_t         state_q, state_d;
    hz_state_t         ret_q, ret_d;
    hz_state_t         evalState;
    logic [FW-1:0]     fcnt_q, fcnt_d;
    logic [WW-1:0]     wcnt_q, wcnt_d;
    logic              timeout_q, timeout_d;
    logic              loadUse;
    logic              pcWrite, ifidWrite, pipeEn, ctrlSel;
    logic              flushIfid, flushIdex, flushExmem;

    assign loadUse = ex_memRead && (ex_rd != '0) &&
                     ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));

    // Leaving MEM_WAIT behaves exactly like the state that was frozen, in the same cycle.
    assign evalState = (state_q == MEM_WAIT) ? ret_q : state_q;

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        fcnt_d     = fcnt_q;
        pcWrite    = 1'b1;
        ifidWrite  = 1'b1;
        pipeEn     = 1'b1;
        ctrlSel    = 1'b1;
        flushIfid  = 1'b0;
        flushIdex  = 1'b0;
        flushExmem = 1'b0;
        if (dmem_busy) begin
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            pipeEn    = 1'b0;
            state_d   = MEM_WAIT;
            ret_d     = evalState;
        end else if (evalState == FLUSH) begin
            flushIfid = 1'b1;
            if (fcnt_q == FW'(1)) begin
                state_d = RUN;
            end else begin
                fcnt_d  = fcnt_q - FW'(1);
                state_d = FLUSH;
            end
        end else begin
            state_d = RUN;
            if (branch_taken) begin
                ctrlSel    = 1'b0;
                flushIfid  = 1'b1;
                flushIdex  = 1'b1;
                flushExmem = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    fcnt_d  = FW'(FLUSH_CYCLES - 1);
                    state_d = FLUSH;
                end
            end else if (loadUse) begin
                pcWrite   = 1'b0;
                ifidWrite = 1'b0;
                ctrlSel   = 1'b0;
            end
        end
    end

    // Consecutive-busy watchdog; the timeout flag is sticky until reset.
    always_comb begin
        wcnt_d = '0;
        if (dmem_busy) begin
            wcnt_d = (wcnt_q == WW'(MAX_WAIT)) ? wcnt_q : wcnt_q + WW'(1);
        end
        timeout_d = timeout_q || (wcnt_d == WW'(MAX_WAIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            ret_q     <= RUN;
            fcnt_q    <= '0;
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            fcnt_q    <= fcnt_d;
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign pc_write      = rst_n & pcWrite;
    assign ifid_write    = rst_n & ifidWrite;
    assign pipe_en       = rst_n & pipeEn;
    assign ctrl_sel      = rst_n & ctrlSel;
    assign flush_ifid    = rst_n & flushIfid;
    assign flush_idex    = rst_n & flushIdex;
    assign flush_exmem   = rst_n & flushExmem;
    assign stall_timeout = rst_n & timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    // Events are recovered from the output pattern: a bubble keeps pipe_en, a freeze drops it.
    logic [31:0] perfLu_q, perfFl_q, perfMw_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perfLu_q <= '0;
            perfFl_q <= '0;
            perfMw_q <= '0;
        end else begin
            if (!pcWrite && pipeEn) perfLu_q <= perfLu_q + 32'd1;
            if (flushExmem)         perfFl_q <= perfFl_q + 32'd1;
            if (!pipeEn)            perfMw_q <= perfMw_q + 32'd1;
        end
    end

    assign perf_lu_stalls = perfLu_q;
    assign perf_flushes   = perfFl_q;
    assign perf_mem_waits = perfMw_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then randomized traffic vs a behavioural model.
module tb_hazard_ctrl;

    localparam int AW = 5;
    localparam int FC = 3;
    localparam int MW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_memRead, branch_taken, dmem_busy;
    logic          pc_write, ifid_write, pipe_en, ctrl_sel;
    logic          flush_ifid, flush_idex, flush_exmem, stall_timeout;

    int checks = 0;
    int errors = 0;

    // Model state: flush-only cycles still owed, current busy run length, sticky timeout.
    int flushLeft;
    int busyRun;
    bit timeoutSeen;

    hazard_ctrl #(.REG_AW(AW), .FLUSH_CYCLES(FC), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_memRead(ex_memRead), .ex_rd(ex_rd), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
        .pc_write(pc_write), .ifid_write(ifid_write), .pipe_en(pipe_en), .ctrl_sel(ctrl_sel),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
        .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    // Expected {pc_write, ifid_write, pipe_en, ctrl_sel, flush_ifid, flush_idex, flush_exmem, stall_timeout}.
    function automatic logic [7:0] expectedOutputs();
        logic hazard;
        logic [6:0] ctl;
        if (!rst_n) return 8'b0;
        hazard = ex_memRead && (ex_rd != 0) &&
                 ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
        if (dmem_busy)          ctl = 7'b0001_000;
        else if (flushLeft > 0) ctl = 7'b1111_100;
        else if (branch_taken)  ctl = 7'b1110_111;
        else if (hazard)        ctl = 7'b0010_000;
        else                    ctl = 7'b1111_000;
        return {ctl, timeoutSeen};
    endfunction

    task automatic modelReset();
        flushLeft   = 0;
        busyRun     = 0;
        timeoutSeen = 1'b0;
    endtask

    task automatic modelEdge();
        if (dmem_busy) begin
            busyRun = (busyRun < MW) ? busyRun + 1 : MW;
            if (busyRun == MW) timeoutSeen = 1'b1;
        end else begin
            busyRun = 0;
            if (flushLeft > 0)     flushLeft = flushLeft - 1;
            else if (branch_taken) flushLeft = FC - 1;
        end
    endtask

    task automatic applyStimulus(input logic rn, input logic mr, input logic [AW-1:0] rd,
                                 input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                                 input logic u1, input logic u2, input logic br, input logic busy);
        @(negedge clk);
        rst_n = rn; ex_memRead = mr; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_use_rs1 = u1; id_use_rs2 = u2; branch_taken = br; dmem_busy = busy;
        #1;
        if (!rst_n) modelReset();
    endtask

    task automatic checkOutput(input string tag);
        logic [7:0] obs;
        logic [7:0] exp;
        obs = {pc_write, ifid_write, pipe_en, ctrl_sel, flush_ifid, flush_idex, flush_exmem, stall_timeout};
        exp = expectedOutputs();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input string tag, input logic rn, input logic mr, input logic [AW-1:0] rd,
                        input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic u1, input logic u2, input logic br, input logic busy);
        applyStimulus(rn, mr, rd, rs1, rs2, u1, u2, br, busy);
        checkOutput(tag);
        @(posedge clk);
        if (rst_n) modelEdge();
    endtask

    initial begin
        logic busyR, brR, rnR;
        modelReset();
        rst_n = 1'b0;
        {ex_memRead, id_use_rs1, id_use_rs2, branch_taken, dmem_busy} = '0;
        {ex_rd, id_rs1, id_rs2} = '0;

        step("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("reset_busy", 0, 1, 5, 5, 0, 1, 0, 1, 1);
        step("idle", 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Load-use detection and its qualifiers.
        step("lu_rs1", 1, 1, 5, 5, 0, 1, 0, 0, 0);
        step("after_lu", 1, 0, 5, 5, 0, 1, 0, 0, 0);
        step("lu_rd0", 1, 1, 0, 0, 0, 1, 0, 0, 0);
        step("lu_nouse", 1, 1, 5, 5, 0, 0, 0, 0, 0);
        step("lu_rs2", 1, 1, 7, 3, 7, 0, 1, 0, 0);
        step("lu_noload", 1, 0, 7, 3, 7, 0, 1, 0, 0);

        // Taken branch with a three-cycle flush; load-use is ignored while flushing.
        step("br_redirect", 1, 0, 0, 0, 0, 0, 0, 1, 0);
        step("br_flush1", 1, 1, 5, 5, 0, 1, 0, 0, 0);
        step("br_flush2", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("br_done", 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Memory freeze with branch pending, then the deferred redirect.
        for (int i = 0; i < 4; i++) step("busy_branch", 1, 0, 0, 0, 0, 0, 0, 1, 1);
        step("deferred_redirect", 1, 0, 0, 0, 0, 0, 0, 1, 0);
        step("deferred_flush1", 1, 0, 0, 0, 0, 0, 0, 0, 1);
        step("deferred_flush1b", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("deferred_flush2", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("deferred_done", 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Watchdog: eight consecutive busy cycles set a sticky timeout.
        for (int i = 0; i < MW; i++) step("busy_run", 1, 0, 0, 0, 0, 0, 0, 0, 1);
        step("timeout_set", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("timeout_sticky", 1, 1, 4, 4, 0, 1, 0, 0, 0);

        // Reset in the middle of a flush clears everything immediately.
        step("rst_redirect", 1, 0, 0, 0, 0, 0, 0, 1, 0);
        step("rst_mid_flush", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("post_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("post_rst2", 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic, including long busy runs and occasional resets.
        busyR = 1'b0;
        brR   = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            rnR = ($urandom_range(0, 199) != 0);
            if (busyR) busyR = ($urandom_range(0, 7) != 0);
            else       busyR = ($urandom_range(0, 5) == 0);
            if (!busyR) brR = ($urandom_range(0, 7) == 0);
            step("random", rnR, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                 AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), brR, busyR);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
